// File: rtl/banked_mem.sv
// -----------------------------------------------------------------------------
// banked_mem
//   Four-bank, word-interleaved 16-bit memory. Each bank holds 2^IDX_W words
//   and stays occupied for BUSY_CYC cycles after it accepts an access. A request
//   to an occupied bank is refused (stall) and dropped; the requester must
//   present it again. Reads return data with a fixed two-cycle latency.
//
// Parameters
//   IDX_W    : per-bank word-index width (bank depth = 2^IDX_W words)
//   BUSY_CYC : cycles a bank is occupied per accepted access, including the
//              accept cycle (2..4)
//
// Ports
//   clk      : clock, all state changes on the rising edge
//   rst      : asynchronous, active-high reset
//   addr     : byte address; bank = addr[2:1], index = addr[IDX_W+2:3]
//   data_in  : write data
//   rd, wr   : read / write request (both high is illegal)
//   data_out : registered read data, holds its value between completions
//   done     : one-cycle pulse marking data_out valid
//   stall    : combinational, current request refused because its bank is busy
//   busy     : one bit per bank, bank occupied
//   err      : combinational, illegal request (rd & wr, or odd address)
// -----------------------------------------------------------------------------
module banked_mem #(
   parameter int IDX_W    = 13,
   parameter int BUSY_CYC = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] addr,
   input  logic [15:0] data_in,
   input  logic        rd,
   input  logic        wr,
   output logic [15:0] data_out,
   output logic        done,
   output logic        stall,
   output logic [3:0]  busy,
   output logic        err
);

   localparam int         DEPTH   = 1 << IDX_W;
   localparam logic [1:0] LP_LOAD = 2'(BUSY_CYC - 1);

   // Memory is deliberately left without reset so it maps onto plain RAM.
   logic [15:0]        r_mem [0:4*DEPTH-1];
   logic [1:0]         r_cnt [0:3];
   logic               r_v1;
   logic [15:0]        r_d1;
   logic               r_done;
   logic [15:0]        r_data_out;

   logic [1:0]         w_bank;
   logic [IDX_W-1:0]   w_idx;
   logic [IDX_W+1:0]   w_word;
   logic               w_req;
   logic               w_err;
   logic               w_stall;
   logic               w_acc;
   logic [3:0]         w_busy;

   assign w_bank = addr[2:1];
   assign w_idx  = addr[IDX_W+2:3];
   assign w_word = {w_bank, w_idx};
   assign w_req  = rd ^ wr;

   // Occupancy flags derived from the per-bank down-counters.
   always_comb begin
      w_busy = 4'b0000;
      for (int b = 0; b < 4; b++) begin
         if (r_cnt[b] != 2'd0) begin
            w_busy[b] = 1'b1;
         end else begin
            w_busy[b] = 1'b0;
         end
      end
   end

   // Request classification: illegal, refused, or accepted.
   always_comb begin
      w_err   = (rd & wr) | ((rd | wr) & addr[0]);
      w_stall = w_req & w_busy[w_bank] & ~w_err;
      w_acc   = w_req & ~w_err & ~w_stall;
   end

   // Per-bank occupancy counters: load on accept, count down to zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < 4; b++) begin
            r_cnt[b] <= 2'd0;
         end
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (w_acc && (w_bank == 2'(b))) begin
               r_cnt[b] <= LP_LOAD;
            end else if (r_cnt[b] != 2'd0) begin
               r_cnt[b] <= r_cnt[b] - 2'd1;
            end else begin
               r_cnt[b] <= 2'd0;
            end
         end
      end
   end

   // Array write and first-stage read capture. Bank occupancy guarantees a
   // read never overlaps a write to the same bank, so no bypass is needed.
   always_ff @(posedge clk) begin
      if (w_acc && wr) begin
         r_mem[w_word] <= data_in;
      end
      if (w_acc && rd) begin
         r_d1 <= r_mem[w_word];
      end
   end

   // Read pipeline valid bits and the registered output stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v1       <= 1'b0;
         r_done     <= 1'b0;
         r_data_out <= 16'h0000;
      end else begin
         r_v1   <= w_acc & rd;
         r_done <= r_v1;
         if (r_v1) begin
            r_data_out <= r_d1;
         end
      end
   end

   assign data_out = r_data_out;
   assign done     = r_done;
   assign busy     = w_busy;
   assign stall    = w_stall;
   assign err      = w_err;

endmodule
